id_decode_stage: RTL and testbench

- Instruction-decode stage of the 5-stage MIPS pipeline; sits between the IF/ID latch and the ID/EX latch and drives every input of the ID/EX latch.
- Contains:
  - the 32x32 register file, with write-through bypass from write-back;
  - the main control decoder;
  - the 16-to-32 sign extender;
  - load-use hazard detection, which stalls PC and IF/ID and injects a bubble.
- Also keeps a saturating stall counter for performance monitoring.

---
 rtl/id_decode_stage_if.sv | 58 +++++
 rtl/id_decode_stage.sv | 150 +++++++++++++++
 tb/tb_id_decode_stage.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_decode_stage_if.sv
// Pipeline-side bundle for the ID stage: IF/ID inputs, write-back port,
// hazard inputs from ID/EX, and everything the stage drives into ID/EX.
interface id_decode_stage_if #(
  parameter int B  = 32,
  parameter int W  = 5,
  parameter int CW = 8
);
  // From IF/ID latch
  logic [31:0]   instr_in;
  logic [W-1:0]  pc_next_in;
  // Write-back port
  logic          wb_reg_write;
  logic [W-1:0]  wb_write_reg;
  logic [B-1:0]  wb_write_data;
  // From ID/EX latch (hazard detection)
  logic          ex_mem_read;
  logic [W-1:0]  ex_rt;
  // To ID/EX latch
  logic [W-1:0]  pc_next_out;
  logic [B-1:0]  r_data1;
  logic [B-1:0]  r_data2;
  logic [B-1:0]  sign_ext;
  logic [W-1:0]  inst_20_16;
  logic [W-1:0]  inst_15_11;
  logic          wb_RegWrite;
  logic          wb_MemtoReg;
  logic          m_Branch;
  logic          m_MemRead;
  logic          m_MemWrite;
  logic          ex_RegDst;
  logic          ex_ALUOp0;
  logic          ex_ALUOp1;
  logic          ex_ALUSrc;
  // Pipeline enables and performance counter
  logic          pc_write;
  logic          if_id_write;
  logic [CW-1:0] stall_count;

  // Pipeline side: feeds the stage and consumes its results
  modport master (
    output instr_in, pc_next_in, wb_reg_write, wb_write_reg, wb_write_data,
           ex_mem_read, ex_rt,
    input  pc_next_out, r_data1, r_data2, sign_ext, inst_20_16, inst_15_11,
           wb_RegWrite, wb_MemtoReg, m_Branch, m_MemRead, m_MemWrite,
           ex_RegDst, ex_ALUOp0, ex_ALUOp1, ex_ALUSrc,
           pc_write, if_id_write, stall_count
  );

  // Decode stage side
  modport slave (
    input  instr_in, pc_next_in, wb_reg_write, wb_write_reg, wb_write_data,
           ex_mem_read, ex_rt,
    output pc_next_out, r_data1, r_data2, sign_ext, inst_20_16, inst_15_11,
           wb_RegWrite, wb_MemtoReg, m_Branch, m_MemRead, m_MemWrite,
           ex_RegDst, ex_ALUOp0, ex_ALUOp1, ex_ALUSrc,
           pc_write, if_id_write, stall_count
  );
endinterface

// File: rtl/id_decode_stage.sv
// MIPS 5-stage pipeline instruction-decode stage: register file with
// write-through bypass from write-back, main control decoder, sign extender,
// load-use hazard detection with bubble injection, saturating stall counter.
module id_decode_stage #(
  parameter int B  = 32,
  parameter int W  = 5,
  parameter int CW = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  id_decode_stage_if.slave bus
);

  localparam int unsigned NREG = 1 << W;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_BEQ   = 6'b000100,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic branch;
    logic mem_read;
    logic mem_write;
    logic reg_dst;
    logic alu_op0;
    logic alu_op1;
    logic alu_src;
  } ctrl_t;

  logic [B-1:0]  regs_q [NREG];
  logic [CW-1:0] stall_cnt_q;
  logic [CW-1:0] stall_cnt_d;

  logic [W-1:0]  rs_addr;
  logic [W-1:0]  rt_addr;
  logic          wb_hit;
  logic          stall;
  ctrl_t         ctrl;

  assign rs_addr = bus.instr_in[25:21];
  assign rt_addr = bus.instr_in[20:16];

  // A write-back to $0 is never a real write: it neither updates nor bypasses
  assign wb_hit = bus.wb_reg_write && (bus.wb_write_reg != '0);

  // Register file storage; $0 is never written so it always reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_hit) begin
      regs_q[bus.wb_write_reg] <= bus.wb_write_data;
    end
  end

  // Combinational operand read with same-cycle bypass from write-back
  always_comb begin
    bus.r_data1 = regs_q[rs_addr];
    bus.r_data2 = regs_q[rt_addr];
    if (wb_hit && (bus.wb_write_reg == rs_addr)) begin
      bus.r_data1 = bus.wb_write_data;
    end
    if (wb_hit && (bus.wb_write_reg == rt_addr)) begin
      bus.r_data2 = bus.wb_write_data;
    end
  end

  // Field pass-through and immediate sign extension
  always_comb begin
    bus.sign_ext    = {{(B-16){bus.instr_in[15]}}, bus.instr_in[15:0]};
    bus.inst_20_16  = rt_addr;
    bus.inst_15_11  = bus.instr_in[15:11];
    bus.pc_next_out = bus.pc_next_in;
  end

  // Load-use hazard: the load in EX writes a register this instruction reads.
  // No opcode qualification, so ex_rt==0 also stalls.
  assign stall = bus.ex_mem_read &&
                 ((bus.ex_rt == rs_addr) || (bus.ex_rt == rt_addr));

  // Main control decode; a stall replaces the decoded word with a bubble
  always_comb begin
    ctrl = '0;
    if (!stall) begin
      case (bus.instr_in[31:26])
        OP_RTYPE: begin
          ctrl.reg_dst   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op1   = 1'b1;
        end
        OP_LW: begin
          ctrl.alu_src    = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.mem_read   = 1'b1;
        end
        OP_SW: begin
          ctrl.alu_src   = 1'b1;
          ctrl.mem_write = 1'b1;
        end
        OP_BEQ: begin
          ctrl.branch  = 1'b1;
          ctrl.alu_op0 = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

  // Drive control bits and pipeline enables toward ID/EX, PC and IF/ID
  always_comb begin
    bus.wb_RegWrite = ctrl.reg_write;
    bus.wb_MemtoReg = ctrl.mem_to_reg;
    bus.m_Branch    = ctrl.branch;
    bus.m_MemRead   = ctrl.mem_read;
    bus.m_MemWrite  = ctrl.mem_write;
    bus.ex_RegDst   = ctrl.reg_dst;
    bus.ex_ALUOp0   = ctrl.alu_op0;
    bus.ex_ALUOp1   = ctrl.alu_op1;
    bus.ex_ALUSrc   = ctrl.alu_src;
    bus.pc_write    = !stall;
    bus.if_id_write = !stall;
  end

  // Saturating stall counter next state
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: directed scenarios plus randomized traffic
// checked against a behavioural model of the register file, decoder,
// hazard rule and saturating stall counter.
module tb_id_decode_stage;

  localparam int B  = 32;
  localparam int W  = 5;
  localparam int CW = 8;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] mregs [32];
  int          mcnt;

  id_decode_stage_if #(.B(B), .W(W), .CW(CW)) bus ();

  id_decode_stage #(.B(B), .W(W), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model_ctrl(input logic [5:0] op);
    // {RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUOp0, ALUOp1, ALUSrc}
    case (op)
      6'h00:   return 9'b100001010;
      6'h23:   return 9'b110100001;
      6'h2b:   return 9'b000010001;
      6'h04:   return 9'b001000100;
      default: return 9'b000000000;
    endcase
  endfunction

  function automatic logic model_stall();
    int rs = int'(bus.instr_in[25:21]);
    int rt = int'(bus.instr_in[20:16]);
    int er = int'(bus.ex_rt);
    return bus.ex_mem_read && (er == rs || er == rt);
  endfunction

  function automatic logic [31:0] model_read(input int addr);
    if (addr == 0) return 32'h0;
    if (bus.wb_reg_write && int'(bus.wb_write_reg) == addr) return bus.wb_write_data;
    return mregs[addr];
  endfunction

  function automatic logic [8:0] dut_ctrl();
    return {bus.wb_RegWrite, bus.wb_MemtoReg, bus.m_Branch, bus.m_MemRead,
            bus.m_MemWrite, bus.ex_RegDst, bus.ex_ALUOp0, bus.ex_ALUOp1, bus.ex_ALUSrc};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    mcnt = 0;
  endtask

  // Compare every output against the model for the current inputs
  task automatic check_outputs(input string tag);
    logic        st;
    logic [31:0] sx;
    st = model_stall();
    sx = 32'(int'($signed(bus.instr_in[15:0])));
    check_eq({tag, ".rd1"}, 64'(bus.r_data1), 64'(model_read(int'(bus.instr_in[25:21]))));
    check_eq({tag, ".rd2"}, 64'(bus.r_data2), 64'(model_read(int'(bus.instr_in[20:16]))));
    check_eq({tag, ".sext"}, 64'(bus.sign_ext), 64'(sx));
    check_eq({tag, ".rt"}, 64'(bus.inst_20_16), 64'(bus.instr_in[20:16]));
    check_eq({tag, ".rd"}, 64'(bus.inst_15_11), 64'(bus.instr_in[15:11]));
    check_eq({tag, ".pcn"}, 64'(bus.pc_next_out), 64'(bus.pc_next_in));
    check_eq({tag, ".ctrl"}, 64'(dut_ctrl()), st ? 64'h0 : 64'(model_ctrl(bus.instr_in[31:26])));
    check_eq({tag, ".pcw"}, 64'(bus.pc_write), 64'(!st));
    check_eq({tag, ".ifidw"}, 64'(bus.if_id_write), 64'(!st));
    check_eq({tag, ".cnt"}, 64'(bus.stall_count), 64'(mcnt));
  endtask

  // One clock: model follows the rising edge, inputs change after falling edge
  task automatic tick();
    logic st;
    st = model_stall();
    @(posedge clk);
    if (rst_n) begin
      if (bus.wb_reg_write && bus.wb_write_reg != 5'd0)
        mregs[int'(bus.wb_write_reg)] = bus.wb_write_data;
      if (st && mcnt < 255) mcnt++;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk_instr(input logic [5:0] op, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    logic [5:0] ops [5];
    logic [5:0] op;
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2b; ops[3] = 6'h04; ops[4] = 6'h0d;

    rst_n             = 1'b0;
    bus.instr_in      = mk_instr(6'h00, 5'd5, 5'd0, 16'h0);
    bus.pc_next_in    = 5'd4;
    bus.wb_reg_write  = 1'b0;
    bus.wb_write_reg  = 5'd0;
    bus.wb_write_data = 32'h0;
    bus.ex_mem_read   = 1'b0;
    bus.ex_rt         = 5'd0;
    model_reset();
    #3;
    check_outputs("in_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs("post_reset");
    check_eq("reset_rd1", 64'(bus.r_data1), 64'h0);
    check_eq("reset_cnt", 64'(bus.stall_count), 64'h0);
    tick();

    // Bypass on write to $7 while reading it
    bus.wb_reg_write  = 1'b1;
    bus.wb_write_reg  = 5'd7;
    bus.wb_write_data = 32'hDEADBEEF;
    bus.instr_in      = mk_instr(6'h00, 5'd7, 5'd1, 16'h0);
    #1;
    check_eq("bypass_rd1", 64'(bus.r_data1), 64'hDEADBEEF);
    check_outputs("bypass");
    tick();
    bus.wb_reg_write = 1'b0;
    #1;
    check_eq("persist_rd1", 64'(bus.r_data1), 64'hDEADBEEF);
    check_outputs("persist");

    // Rt bypass with rs==rt
    bus.wb_reg_write  = 1'b1;
    bus.wb_write_reg  = 5'd9;
    bus.wb_write_data = 32'hCAFE0001;
    bus.instr_in      = mk_instr(6'h00, 5'd9, 5'd9, 16'h0);
    #1;
    check_eq("dual_bypass_rd1", 64'(bus.r_data1), 64'hCAFE0001);
    check_eq("dual_bypass_rd2", 64'(bus.r_data2), 64'hCAFE0001);
    tick();

    // Write to $0 is ignored
    bus.wb_write_reg  = 5'd0;
    bus.wb_write_data = 32'h12345678;
    bus.instr_in      = mk_instr(6'h00, 5'd0, 5'd0, 16'h0);
    #1;
    check_eq("zero_bypass", 64'(bus.r_data1), 64'h0);
    tick();
    bus.wb_reg_write = 1'b0;
    #1;
    check_eq("zero_read", 64'(bus.r_data1), 64'h0);

    // lw $2,16($1)
    bus.instr_in = 32'h8C220010;
    #1;
    check_eq("lw_ctrl", 64'(dut_ctrl()), 64'(9'b110100001));
    check_eq("lw_sext", 64'(bus.sign_ext), 64'h00000010);
    check_outputs("lw");
    tick();

    // Load-use stall then recovery
    bus.ex_mem_read = 1'b1;
    bus.ex_rt       = 5'd2;
    bus.instr_in    = 32'h00431020;
    #1;
    check_eq("lu_pcw", 64'(bus.pc_write), 64'h0);
    check_eq("lu_ifidw", 64'(bus.if_id_write), 64'h0);
    check_eq("lu_ctrl", 64'(dut_ctrl()), 64'h0);
    check_eq("lu_cnt0", 64'(bus.stall_count), 64'h0);
    tick();
    bus.ex_mem_read = 1'b0;
    #1;
    check_eq("lu_cnt1", 64'(bus.stall_count), 64'h1);
    check_eq("lu_rtype", 64'(dut_ctrl()), 64'(9'b100001010));
    check_eq("lu_pcw_back", 64'(bus.pc_write), 64'h1);
    check_outputs("lu_recover");
    tick();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      op = ops[$urandom_range(0, 4)];
      if (op == 6'h0d) op = 6'($urandom);
      bus.instr_in      = mk_instr(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                   16'($urandom));
      bus.pc_next_in    = 5'($urandom);
      bus.wb_reg_write  = 1'($urandom_range(0, 1));
      bus.wb_write_reg  = 5'($urandom_range(0, 9));
      bus.wb_write_data = $urandom;
      bus.ex_mem_read   = ($urandom_range(0, 2) == 0);
      bus.ex_rt         = 5'($urandom_range(0, 7));
      #1;
      check_outputs("rand");
      tick();
    end

    // Saturation: hold a stall for 300 cycles
    bus.wb_reg_write = 1'b0;
    bus.instr_in     = mk_instr(6'h00, 5'd4, 5'd5, 16'h0);
    bus.ex_mem_read  = 1'b1;
    bus.ex_rt        = 5'd4;
    for (int n = 0; n < 300; n++) begin
      #1;
      check_outputs("sat");
      tick();
    end
    #1;
    check_eq("sat_cnt", 64'(bus.stall_count), 64'd255);

    // Asynchronous reset mid-cycle
    bus.ex_mem_read = 1'b0;
    bus.instr_in    = mk_instr(6'h00, 5'd7, 5'd9, 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_cnt", 64'(bus.stall_count), 64'h0);
    check_eq("arst_rd1", 64'(bus.r_data1), 64'h0);
    check_eq("arst_rd2", 64'(bus.r_data2), 64'h0);
    for (int r = 1; r < 8; r++) begin
      bus.instr_in = mk_instr(6'h00, 5'(r), 5'(r + 1), 16'h0);
      #1;
      check_outputs("arst_regs");
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      bus.instr_in      = mk_instr(ops[$urandom_range(0, 3)], 5'($urandom_range(0, 3)),
                                   5'($urandom_range(0, 3)), 16'($urandom));
      bus.wb_reg_write  = 1'($urandom_range(0, 1));
      bus.wb_write_reg  = 5'($urandom_range(0, 3));
      bus.wb_write_data = $urandom;
      bus.ex_mem_read   = 1'($urandom_range(0, 1));
      bus.ex_rt         = 5'($urandom_range(0, 3));
      #1;
      check_outputs("post_arst");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
